// File: rtl/one_bit_pair_gen_if.sv
// Pair stream between the generator and its consumer: valid/ready handshake
// carrying one operand pair plus the parity reference for the current run.
interface one_bit_pair_gen_if #(
    parameter int N_BITS = 5
);
    logic              out_valid;
    logic              out_ready;
    logic [N_BITS-1:0] number1;
    logic [N_BITS-1:0] number2;
    logic              out_balance;

    modport master (
        output out_valid,
        output number1,
        output number2,
        output out_balance,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  number1,
        input  number2,
        input  out_balance,
        output out_ready
    );
endinterface

// File: rtl/one_bit_pair_gen.sv
// Enumerates every {number1,number2} pair whose combined one-count equals the
// requested target, in ascending order, and streams the pairs out.
module one_bit_pair_gen #(
    parameter int N_BITS  = 5,
    parameter int MATCH_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         target,
    output logic               busy,
    output logic [MATCH_W-1:0] match_count,
    output logic               done,
    output logic               error,
    one_bit_pair_gen_if.master pair
);
    localparam int CAND_W = 2 * N_BITS;
    localparam int CNT_W  = $clog2(CAND_W + 1);
    localparam logic [CAND_W-1:0] CAND_MAX = {CAND_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] popcount(input logic [CAND_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = {CNT_W{1'b0}};
        for (int i = 0; i < CAND_W; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Even parity of the requested count: 1 when target has an even number of ones
    function automatic logic even_parity(input logic [3:0] v);
        return ~^v;
    endfunction

    state_t              state_r, state_s;
    logic [CAND_W-1:0]   cand_r, cand_s;
    logic [3:0]          target_r, target_s;
    logic                valid_r, valid_s;
    logic [N_BITS-1:0]   num1_r, num1_s;
    logic [N_BITS-1:0]   num2_r, num2_s;
    logic                bal_r, bal_s;
    logic [MATCH_W-1:0]  cnt_r, cnt_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;
    logic                error_r, error_s;

    // Next-state and next-output logic for the scan/emit sequencer
    always_comb begin
        state_s  = state_r;
        cand_s   = cand_r;
        target_s = target_r;
        valid_s  = valid_r;
        num1_s   = num1_r;
        num2_s   = num2_r;
        bal_s    = bal_r;
        cnt_s    = cnt_r;
        done_s   = 1'b0;
        error_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (target > 4'd10) begin
                        error_s = 1'b1;
                    end else begin
                        target_s = target;
                        bal_s    = even_parity(target);
                        cand_s   = {CAND_W{1'b0}};
                        cnt_s    = {MATCH_W{1'b0}};
                        state_s  = ST_SCAN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (popcount(cand_r) == CNT_W'(target_r)) begin
                    num1_s  = cand_r[CAND_W-1:N_BITS];
                    num2_s  = cand_r[N_BITS-1:0];
                    valid_s = 1'b1;
                    state_s = ST_EMIT;
                end else if (cand_r != CAND_MAX) begin
                    cand_s = cand_r + CAND_W'(1);
                end else begin
                    done_s  = 1'b1;
                    state_s = ST_DONE;
                end
            end
            ST_EMIT: begin
                if (pair.out_ready) begin
                    valid_s = 1'b0;
                    cnt_s   = cnt_r + MATCH_W'(1);
                    // The last candidate must not wrap back to zero
                    if (cand_r == CAND_MAX) begin
                        done_s  = 1'b1;
                        state_s = ST_DONE;
                    end else begin
                        cand_s  = cand_r + CAND_W'(1);
                        state_s = ST_SCAN;
                    end
                end else begin
                    valid_s = 1'b1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State and registered-output update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cand_r   <= {CAND_W{1'b0}};
            target_r <= 4'd0;
            valid_r  <= 1'b0;
            num1_r   <= {N_BITS{1'b0}};
            num2_r   <= {N_BITS{1'b0}};
            bal_r    <= 1'b0;
            cnt_r    <= {MATCH_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            error_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            cand_r   <= cand_s;
            target_r <= target_s;
            valid_r  <= valid_s;
            num1_r   <= num1_s;
            num2_r   <= num2_s;
            bal_r    <= bal_s;
            cnt_r    <= cnt_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            error_r  <= error_s;
        end
    end

    assign pair.out_valid   = valid_r;
    assign pair.number1     = num1_r;
    assign pair.number2     = num2_r;
    assign pair.out_balance = bal_r;
    assign busy             = busy_r;
    assign match_count      = cnt_r;
    assign done             = done_r;
    assign error            = error_r;
endmodule

// File: tb/tb_one_bit_pair_gen.sv
// Randomized self-checking bench for one_bit_pair_gen; expected pair lists are
// built by brute-force enumeration with $countones.
module tb_one_bit_pair_gen;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] target = 4'd0;
    logic       busy, done, error;
    logic [7:0] match_count;

    one_bit_pair_gen_if #(.N_BITS(5)) pif();

    one_bit_pair_gen #(.N_BITS(5), .MATCH_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .target(target),
        .busy(busy), .match_count(match_count), .done(done), .error(error),
        .pair(pif)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];
    int r_cycles, r_stalls;
    bit r_timeout, r_busy_at_done, r_bal_at_done;
    int last_count_exp = 0;

    function automatic void build_model(input int t);
        logic [9:0] w;
        exp_q.delete();
        for (int v = 0; v < 1024; v++) begin
            w = v[9:0];
            if ($countones(w) == t) exp_q.push_back(w);
        end
    endfunction

    function automatic int binom(input int n, input int k);
        int c;
        c = 1;
        for (int i = 0; i < k; i++) c = c * (n - i) / (i + 1);
        return c;
    endfunction

    function automatic bit model_balance(input logic [3:0] t);
        return ($countones(t) % 2) == 0;
    endfunction

    // returns index of first difference between got_q and exp_q, -1 if identical
    function automatic int first_diff();
        if (got_q.size() != exp_q.size()) return 0;
        for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic run_collect(input logic [3:0] t, input int ready_pct, input int stop_after);
        bit held;
        logic [9:0] held_pair;
        bit rdy;
        got_q.delete();
        r_stalls = 0; r_timeout = 0; r_cycles = 0; held = 0; held_pair = 10'd0;
        @(negedge clk);
        start = 1'b1; target = t;
        @(negedge clk);
        start = 1'b0;
        r_cycles = 1;
        while (1) begin
            if (held && (!pif.out_valid || {pif.number1, pif.number2} !== held_pair)) r_stalls++;
            if (done) begin
                r_busy_at_done = busy;
                r_bal_at_done  = pif.out_balance;
                break;
            end
            if (r_cycles > 6000) begin
                r_timeout = 1;
                break;
            end
            rdy = ($urandom_range(99) < ready_pct);
            pif.out_ready = rdy;
            if (pif.out_valid && rdy) begin
                got_q.push_back({pif.number1, pif.number2});
                held = 0;
                if (stop_after > 0 && got_q.size() == stop_after) break;
            end else if (pif.out_valid) begin
                held = 1;
                held_pair = {pif.number1, pif.number2};
            end else begin
                held = 0;
            end
            @(negedge clk);
            r_cycles++;
        end
        pif.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_tests++;
        if ({busy, pif.out_valid, pif.number1, pif.number2, pif.out_balance, match_count, done, error} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b valid=%b n1=%0d n2=%0d bal=%b cnt=%0d done=%b err=%b, expected all 0",
                     busy, pif.out_valid, pif.number1, pif.number2, pif.out_balance, match_count, done, error);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_run(input string name, input logic [3:0] t, input int ready_pct, input int exp_cycles);
        int d;
        build_model(t);
        run_collect(t, ready_pct, 0);
        n_tests++;
        if (r_timeout) begin
            n_fail++;
            $display("FAIL %s_timeout: got no done within 6000 cycles, expected done", name);
        end
        d = first_diff();
        n_tests++;
        if (d >= 0) begin
            n_fail++;
            $display("FAIL %s_pairs: got %0d pairs (item %0d = %0d), expected %0d pairs (item = %0d)",
                     name, got_q.size(), d, (d < got_q.size()) ? int'(got_q[d]) : -1,
                     exp_q.size(), (d < exp_q.size()) ? int'(exp_q[d]) : -1);
        end
        n_tests++;
        if (match_count !== 8'(binom(10, t))) begin
            n_fail++;
            $display("FAIL %s_count: got %0d, expected %0d", name, match_count, binom(10, t));
        end
        n_tests++;
        if (r_bal_at_done !== model_balance(t) || r_busy_at_done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_balance_busy: got bal=%b busy=%b, expected bal=%b busy=1",
                     name, r_bal_at_done, r_busy_at_done, model_balance(t));
        end
        n_tests++;
        if (r_stalls !== 0) begin
            n_fail++;
            $display("FAIL %s_stable: got %0d unstable stalled cycles, expected 0", name, r_stalls);
        end
        if (exp_cycles > 0) begin
            n_tests++;
            if (r_cycles !== exp_cycles) begin
                n_fail++;
                $display("FAIL %s_latency: got done at cycle %0d, expected %0d", name, r_cycles, exp_cycles);
            end
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_after_done: got done=%b busy=%b, expected 0 0", name, done, busy);
        end
        last_count_exp = binom(10, t);
    endtask

    task automatic test_error_then_run();
        @(negedge clk);
        start = 1'b1; target = 4'd11;
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (error !== 1'b1 || busy !== 1'b0 || pif.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL error_pulse: got err=%b busy=%b valid=%b, expected 1 0 0", error, busy, pif.out_valid);
        end
        @(negedge clk);
        n_tests++;
        if (error !== 1'b0 || busy !== 1'b0 || match_count !== 8'(last_count_exp)) begin
            n_fail++;
            $display("FAIL error_after: got err=%b busy=%b cnt=%0d, expected 0 0 %0d",
                     error, busy, match_count, last_count_exp);
        end
        test_run("after_error_t2", 4'd2, 100, 0);
    endtask

    task automatic test_reset_midrun();
        run_collect(4'd3, 100, 20);
        n_tests++;
        if (got_q.size() !== 20) begin
            n_fail++;
            $display("FAIL midrun_pre: got %0d pairs before reset, expected 20", got_q.size());
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, pif.out_valid, pif.number1, pif.number2, pif.out_balance, match_count, done, error} !== 22'd0) begin
            n_fail++;
            $display("FAIL midrun_reset_state: got busy=%b valid=%b n1=%0d n2=%0d cnt=%0d, expected all 0",
                     busy, pif.out_valid, pif.number1, pif.number2, match_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || pif.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_idle: got busy=%b valid=%b, expected 0 0", busy, pif.out_valid);
        end
        test_run("restart_t3", 4'd3, 100, 0);
        n_tests++;
        if (got_q.size() == 0 || got_q[0] !== 10'd7) begin
            n_fail++;
            $display("FAIL restart_first: got %0d, expected 7", (got_q.size() > 0) ? int'(got_q[0]) : -1);
        end
    endtask

    initial begin
        pif.out_ready = 1'b0;
        test_reset();
        test_run("t0", 4'd0, 100, 1026);
        test_run("t10", 4'd10, 100, 1026);
        test_run("t1", 4'd1, 100, 1024 + 10 + 1);
        test_run("t5_backpressure", 4'd5, 60, 0);
        test_error_then_run();
        test_run("t7_backpressure", 4'($urandom_range(6, 9)), 40, 0);
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/one_bit_pair_gen.md
Name: one_bit_pair_gen

Overview:
Inverse of the team's one-count/balance unit. Given a requested total one-count `target` (0..10), the block enumerates every operand pair (number1, number2) of 5-bit values whose combined number of set bits equals `target`. It streams each pair out over a valid/ready handshake. The pairs serve as stimulus for the ALU popcount path, and the emitted `out_balance` serves as its expected reference value.

Parameters:
N_BITS, 5, width of each operand; the candidate space is 2^(2*N_BITS); only 5 is verified.
MATCH_W, 8, width of `match_count`; must hold C(2*N_BITS, N_BITS), which is 252 at default.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  single-cycle request pulse; sampled only in IDLE.
target  input  4  requested combined one-count; captured with start.
busy  output  1  high from the cycle after an accepted start through the DONE cycle.
out_valid  output  1  number1/number2 hold a matching pair.
out_ready  input  1  consumer accepts the pair when out_valid and out_ready are both high.
number1  output  N_BITS  upper half of candidate (cand[9:5]).
number2  output  N_BITS  lower half of candidate (cand[4:0]).
out_balance  output  1  1 when the number of set bits in target[3:0] is even, else 0; valid while busy.
match_count  output  MATCH_W  pairs handed off so far in current run; holds value after done.
done  output  1  one-cycle pulse at end of a run.
error  output  1  one-cycle pulse when start is accepted with target > 10.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cand=0, busy=0, out_valid=0, number1=0, number2=0, out_balance=0, match_count=0, done=0, error=0. Takes effect immediately, mid-run included. No pair in flight survives reset. After release, the block waits in IDLE for a new start.
- States: IDLE, SCAN, EMIT, DONE.
- IDLE:
  - start=1 with target<=10: latch target, set out_balance, cand=0, match_count=0, go to SCAN.
  - start=1 with target>10: pulse error for one cycle, stay in IDLE, leave match_count unchanged.
  - start while not in IDLE is ignored.
- SCAN: evaluates one candidate per cycle; popcount(cand[9:0]) is compared with the latched target.
  - Match: load number1/number2 from cand, set out_valid=1, go to EMIT (cand not advanced).
  - No match and cand≠1023: cand+1, stay in SCAN.
  - No match and cand=1023: go to DONE.
- EMIT: out_valid stays high and number1/number2 stay stable until handshake. Backpressure of any length is legal.
  - On out_valid&&out_ready: out_valid=0, match_count+1. Then, if cand=1023, go to DONE; otherwise cand+1 and go to SCAN.
- DONE: done=1 for exactly one cycle, busy=0 in the following cycle, return to IDLE.
- Enumeration order: ascending 10-bit {number1,number2}. Each pair is emitted exactly once. Total pairs = C(10,target).
- Run latency: 1024 SCAN cycles, plus one EMIT cycle per match with out_ready held high, plus one DONE cycle.
- start in the same cycle as done: ignored; a new start is accepted only once in IDLE.
- cand is 10 bits and must not wrap past 1023 within a run.
- match_count never exceeds 252 for a legal target.

Test Plan:
- Reset, then start target=0 with out_ready=1 → exactly one pair (0,0), out_balance=1, done pulse, match_count=1.
- target=10 → single pair (31,31), out_balance=1, match_count=1, done roughly 1026 cycles after start.
- target=1 → 10 pairs in order (0,1),(0,2),(0,4),(0,8),(0,16),(1,0),(2,0),(4,0),(8,0),(16,0); out_balance=0, match_count=10.
- target=5 with random out_ready backpressure → 252 pairs, each with combined popcount 5 and no duplicates; pairs stay stable while out_valid && !out_ready; out_balance=1; match_count=252.
- target=11 → error pulse for one cycle, busy stays 0, no out_valid, then a start with target=2 runs normally with 45 pairs.
- Assert rst_n low mid-run (target=3, after 20 pairs) → all outputs return to reset values immediately; a new start with target=3 after release restarts from (0,7).
